// File: rtl/perip_arb_pkg.sv
// Shared definitions for the two-master peripheral port arbiter: master ids,
// arbiter states, read-tag layout and common constants.
package perip_arb_pkg;

  localparam int DATA_BUS = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [DATA_BUS-1:0] DATA_ZERO = '0;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic arb_state_t own_state(input logic id);
    return (id == M_DMA) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/perip_arb_rdtag.sv
// RD_LAT-deep shift register of read tags; the tail names the master whose
// read data is on p_rdata this cycle.
module perip_arb_rdtag
  import perip_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output rd_tag_t tail
);

  rd_tag_t pipe [RD_LAT];

  // NOTE: this array is reset because a stale valid bit would raise a spurious
  // rvalid; a pure data store would be left unreset.
  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // old value, which is what makes this a shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tail = pipe[RD_LAT-1];

endmodule

// File: rtl/perip_arb.sv
// Round-robin arbiter with burst locking sharing one peripheral port between
// the CPU (master 0) and the DMA engine (master 1); read data is routed by tag.
module perip_arb
  import perip_arb_pkg::*;
#(
  parameter int DW       = DATA_BUS,
  parameter int AW       = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_rw,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_rw,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          p_rw,
  output logic [AW-1:0] p_addr,
  output logic [DW-1:0] p_wdata,
  input  logic [DW-1:0] p_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          last;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          owner_keeps;
  logic          gnt_any;
  logic          gnt_id;
  logic          sel_rw;
  logic          sel_lock;
  logic          other_req;
  logic          force_release;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [HW-1:0] cnt_before;
  rd_tag_t       push;
  rd_tag_t       tail;

  // NOTE: gnt_id gets a default first so no path through the chain can
  // leave it unassigned and infer a latch.
  always_comb begin
    gnt_id      = M_CPU;
    owner_keeps = ((state == OWN0) && m0_req) || ((state == OWN1) && m1_req);
    gnt_any     = rst && (m0_req || m1_req);
    if (owner_keeps)           gnt_id = (state == OWN1) ? M_DMA : M_CPU;
    else if (m0_req && m1_req) gnt_id = ~last;
    else if (m1_req)           gnt_id = M_DMA;
  end

  assign sel_rw    = gnt_id ? m1_rw    : m0_rw;
  assign sel_lock  = gnt_id ? m1_lock  : m0_lock;
  assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
  assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;
  assign other_req = gnt_id ? m0_req   : m1_req;

  // A beat that does not continue an existing lock starts a fresh count.
  assign cnt_before    = owner_keeps ? hold_cnt : '0;
  assign force_release = sel_lock && other_req && (cnt_before == HW'(MAX_HOLD - 1));

  assign m0_gnt  = gnt_any && (gnt_id == M_CPU);
  assign m1_gnt  = gnt_any && (gnt_id == M_DMA);
  assign p_rw    = gnt_any && sel_rw;
  assign p_addr  = gnt_any ? sel_addr  : addr_q;
  assign p_wdata = gnt_any ? sel_wdata : wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      last     <= M_DMA;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (gnt_any) begin
      last    <= gnt_id;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      state   <= (sel_lock && !force_release) ? own_state(gnt_id) : IDLE;
      if (sel_lock && other_req && !force_release) hold_cnt <= cnt_before + HW'(1);
      else                                         hold_cnt <= '0;
    end else begin
      state    <= IDLE;
      hold_cnt <= '0;
    end
  end

  assign push.valid = gnt_any && !sel_rw;
  assign push.id    = gnt_id;

  perip_arb_rdtag #(
    .RD_LAT (RD_LAT)
  ) u_rdtag (
    .clk   (clk),
    .rst_n (rst),
    .push  (push),
    .tail  (tail)
  );

  assign m0_rvalid = (tail.valid == ENABLE) && (tail.id == M_CPU);
  assign m1_rvalid = (tail.valid == ENABLE) && (tail.id == M_DMA);
  assign m0_rdata  = m0_rvalid ? p_rdata : DW'(DATA_ZERO);
  assign m1_rdata  = m1_rvalid ? p_rdata : DW'(DATA_ZERO);

endmodule
